// File: rtl/pipe_line_b4_stage_param.sv
// Radix-4 pipeline FFT/IFFT stage: gathers four serial complex samples with
// twiddles, multiplies, runs a 4-point DFT, scales/rounds/saturates and re-serialises.
module pipe_line_b4_stage_param #(
  parameter int WORDLENGTH_IO = 16,
  parameter int WORDLENGTH_WP = 9,
  parameter int SCALE_SHIFT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  input  logic                         inverse,
  input  logic [2*WORDLENGTH_IO-1:0]   data_in,
  input  logic [2*WORDLENGTH_WP-1:0]   omega_in,
  output logic                         out_valid,
  output logic [2*WORDLENGTH_IO-1:0]   data_out,
  output logic                         sat_flag
);

  localparam int IO = WORDLENGTH_IO;
  localparam int WP = WORDLENGTH_WP;
  localparam int PW = IO + WP + 1;  // complex product accumulator
  localparam int TW = IO + 1;       // twiddled sample
  localparam int BW = IO + 3;       // butterfly sum
  localparam int SW = BW + 1;       // scale headroom

  localparam logic signed [PW-1:0] TW_HALF = PW'(1 << (WP - 3));
  localparam logic signed [SW-1:0] RND     = SW'((1 << SCALE_SHIFT) >> 1);
  localparam logic signed [SW-1:0] SMAX    = SW'((1 << (IO - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN    = SW'(-(1 << (IO - 1)));

  // Round-half-up of one part of a complex product back to Q(IO+1).
  function automatic logic signed [TW-1:0] tw_mul(
    input logic signed [IO-1:0] x0,
    input logic signed [IO-1:0] x1,
    input logic signed [WP-1:0] y0,
    input logic signed [WP-1:0] y1,
    input logic                 diff
  );
    logic signed [PW-1:0] p0, p1, acc;
    p0  = PW'(x0) * PW'(y0);
    p1  = PW'(x1) * PW'(y1);
    acc = diff ? (p0 - p1) : (p0 + p1);
    acc = (acc + TW_HALF) >>> (WP - 2);
    return acc[TW-1:0];
  endfunction

  function automatic logic signed [IO-1:0] scale_sat(
    input  logic signed [BW-1:0] x,
    output logic                 clip
  );
    logic signed [SW-1:0] t;
    t    = (SW'(x) + RND) >>> SCALE_SHIFT;
    clip = 1'b0;
    if (t > SMAX) begin
      clip = 1'b1;
      t    = SMAX;
    end else if (t < SMIN) begin
      clip = 1'b1;
      t    = SMIN;
    end
    return t[IO-1:0];
  endfunction

  logic [1:0]              idx;
  logic                    vld_p0, vld_p1, vld_p2;
  logic [1:0]              cnt;

  logic signed [IO-1:0]    smp_re [4];
  logic signed [IO-1:0]    smp_im [4];
  logic signed [WP-1:0]    tw_re  [4];
  logic signed [WP-1:0]    tw_im  [4];
  logic                    inv_p0, inv_p1;

  logic signed [TW-1:0]    x_re_p1 [4];
  logic signed [TW-1:0]    x_im_p1 [4];

  logic signed [BW-1:0]    bf      [8];
  logic signed [BW-1:0]    bf_p2   [8];
  logic signed [IO-1:0]    sc      [8];
  logic [7:0]              clip;
  logic [2*IO-1:0]         ser_buf [3];

  logic signed [BW-1:0]    ar, ai, br, bi, cr, ci, dr, di;
  logic signed [BW-1:0]    s0r, s0i, s1r, s1i, d0r, d0i, kr, ki;

  // 4-point DFT; k = -j(b'-d') carries the kernel sign for f/h
  always_comb begin
    ar  = BW'(x_re_p1[0]);
    ai  = BW'(x_im_p1[0]);
    br  = BW'(x_re_p1[1]);
    bi  = BW'(x_im_p1[1]);
    cr  = BW'(x_re_p1[2]);
    ci  = BW'(x_im_p1[2]);
    dr  = BW'(x_re_p1[3]);
    di  = BW'(x_im_p1[3]);
    s0r = ar + cr;
    s0i = ai + ci;
    s1r = br + dr;
    s1i = bi + di;
    d0r = ar - cr;
    d0i = ai - ci;
    kr  = bi - di;
    ki  = dr - br;
    if (inv_p1) begin
      kr = -kr;
      ki = -ki;
    end
    bf[0] = s0r + s1r;
    bf[1] = s0i + s1i;
    bf[2] = d0r + kr;
    bf[3] = d0i + ki;
    bf[4] = s0r - s1r;
    bf[5] = s0i - s1i;
    bf[6] = d0r - kr;
    bf[7] = d0i - ki;
  end

  always_comb begin
    logic c;
    clip = '0;
    c    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sc[i]   = scale_sat(bf_p2[i], c);
      clip[i] = c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
    end else if (clr) begin
      idx       <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (in_valid) idx <= idx + 2'd1;
      vld_p0 <= in_valid && (idx == 2'd3);
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      // serialiser: e straight out, f/g/h drained from the buffer
      if (vld_p2) begin
        out_valid <= 1'b1;
        data_out  <= {sc[0], sc[1]};
        cnt       <= 2'd3;
        if (|clip) sat_flag <= 1'b1;
      end else if (cnt != 2'd0) begin
        out_valid <= 1'b1;
        data_out  <= ser_buf[0];
        cnt       <= cnt - 2'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // P0: gather
  always_ff @(posedge clk) begin
    if (in_valid) begin
      smp_re[idx] <= data_in[2*IO-1:IO];
      smp_im[idx] <= data_in[IO-1:0];
      tw_re[idx]  <= omega_in[2*WP-1:WP];
      tw_im[idx]  <= omega_in[WP-1:0];
      if (idx == 2'd3) inv_p0 <= inverse;
    end
  end

  // P1: twiddle multiply
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      x_re_p1[0] <= TW'(smp_re[0]);
      x_im_p1[0] <= TW'(smp_im[0]);
      for (int k = 1; k < 4; k++) begin
        x_re_p1[k] <= tw_mul(smp_re[k], smp_im[k], tw_re[k], tw_im[k], 1'b1);
        x_im_p1[k] <= tw_mul(smp_re[k], smp_im[k], tw_im[k], tw_re[k], 1'b0);
      end
      inv_p1 <= inv_p0;
    end
  end

  // P2: butterfly register, then serialiser buffer
  always_ff @(posedge clk) begin
    if (vld_p1) bf_p2 <= bf;
    if (vld_p2) begin
      ser_buf[0] <= {sc[2], sc[3]};
      ser_buf[1] <= {sc[4], sc[5]};
      ser_buf[2] <= {sc[6], sc[7]};
    end else if (cnt != 2'd0) begin
      ser_buf[0] <= ser_buf[1];
      ser_buf[1] <= ser_buf[2];
    end
  end

endmodule

// File: tb/tb_pipe_line_b4_stage_param.sv
// Directed bench for pipe_line_b4_stage_param: two instances (shift 0 and 2)
// share stimulus; outputs are captured into queues and compared to hand values.
module tb_pipe_line_b4_stage_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        inverse = 1'b0;
  logic [31:0] data_in = '0;
  logic [17:0] omega_in = '0;
  logic        ov0, ov2, sf0, sf2;
  logic [31:0] do0, do2;

  pipe_line_b4_stage_param #(.WORDLENGTH_IO(16), .WORDLENGTH_WP(9), .SCALE_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .inverse(inverse),
    .data_in(data_in), .omega_in(omega_in), .out_valid(ov0), .data_out(do0), .sat_flag(sf0)
  );

  pipe_line_b4_stage_param #(.WORDLENGTH_IO(16), .WORDLENGTH_WP(9), .SCALE_SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .inverse(inverse),
    .data_in(data_in), .omega_in(omega_in), .out_valid(ov2), .data_out(do2), .sat_flag(sf2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] d;
    int          c;
  } smp_t;

  smp_t q0[$];
  smp_t q2[$];

  always @(negedge clk) begin
    if (ov0) q0.push_back('{do0, cyc});
    if (ov2) q2.push_back('{do2, cyc});
  end

  int n_chk = 0;
  int n_pass = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] pk(input int re, input int im);
    logic [15:0] r, i;
    r = re[15:0];
    i = im[15:0];
    return {r, i};
  endfunction

  function automatic logic [17:0] pkw(input int re, input int im);
    logic [8:0] r, i;
    r = re[8:0];
    i = im[8:0];
    return {r, i};
  endfunction

  task automatic drive(input logic [31:0] d, input logic [17:0] w, input logic inv);
    in_valid = 1'b1;
    data_in  = d;
    omega_in = w;
    inverse  = inv;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // inverse only held at the 4th sample; earlier samples carry the opposite value
  task automatic send_group(input logic [31:0] d0, d1, d2, d3,
                            input logic [17:0] w1, w2, w3,
                            input logic inv, input int gmax);
    logic [31:0] d[4];
    logic [17:0] w[4];
    d = '{d0, d1, d2, d3};
    w = '{pkw(5, -7), w1, w2, w3};
    for (int k = 0; k < 4; k++) begin
      if (k == 3) acc_cyc = cyc + 1;
      drive(d[k], w[k], (k == 3) ? inv : ~inv);
      if (gmax > 0 && k < 3) idle($urandom_range(gmax, 0));
    end
    in_valid = 1'b0;
    inverse  = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    int t;
    t = 0;
    while (q0.size() < n && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (q0.size() < n) check("timeout", q0.size(), n);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_grp(input string tag, input int sel,
                         input logic [31:0] x0, x1, x2, x3);
    logic [31:0] x[4];
    smp_t q[$];
    x = '{x0, x1, x2, x3};
    if (sel == 0) q = q0;
    else q = q2;
    check({tag, "_n"}, q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q.size()) check($sformatf("%s_%0d", tag, i), q[i].d, x[i]);
  endtask

  task automatic clear_q();
    q0.delete();
    q2.delete();
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ov_held", ov0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ov0", ov0, 0);
    check("rst_do0", do0, 0);
    check("rst_sf0", sf0, 0);
    check("rst_ov2", ov2, 0);

    // DC
    send_group(pk(100, 0), pk(100, 0), pk(100, 0), pk(100, 0),
               pkw(128, 0), pkw(128, 0), pkw(128, 0), 1'b0, 0);
    wait_q(4, 20);
    if (q0.size() >= 4) begin
      check("dc_latency", q0[0].c - acc_cyc, 3);
      check("dc_spacing", q0[3].c - q0[0].c, 3);
    end
    chk_grp("dc0", 0, pk(400, 0), 0, 0, 0);
    chk_grp("dc2", 2, pk(100, 0), 0, 0, 0);
    check("dc_sf0", sf0, 0);
    clear_q();

    // impulse
    send_group(pk(1000, 0), 0, 0, 0, pkw(128, 0), pkw(128, 0), pkw(128, 0), 1'b0, 0);
    wait_q(4, 20);
    chk_grp("imp2", 2, pk(250, 0), pk(250, 0), pk(250, 0), pk(250, 0));
    chk_grp("imp0", 0, pk(1000, 0), pk(1000, 0), pk(1000, 0), pk(1000, 0));
    clear_q();

    // twiddle j, forward
    send_group(0, pk(100, 0), 0, 0, pkw(0, 128), pkw(128, 0), pkw(128, 0), 1'b0, 0);
    wait_q(4, 20);
    chk_grp("twj0", 0, pk(0, 100), pk(100, 0), pk(0, -100), pk(-100, 0));
    chk_grp("twj2", 2, pk(0, 25), pk(25, 0), pk(0, -25), pk(-25, 0));
    clear_q();

    // twiddle j, inverse
    send_group(0, pk(100, 0), 0, 0, pkw(0, 128), pkw(128, 0), pkw(128, 0), 1'b1, 0);
    wait_q(4, 20);
    chk_grp("inv0", 0, pk(0, 100), pk(-100, 0), pk(0, -100), pk(100, 0));
    clear_q();

    // twiddle rounding: 1.5 -> 2, -1.5 -> -1
    send_group(0, pk(3, 0), pk(-3, 0), 0, pkw(64, 0), pkw(64, 0), pkw(128, 0), 1'b0, 0);
    wait_q(4, 20);
    chk_grp("rnd0", 0, pk(1, 0), pk(1, -2), pk(-3, 0), pk(1, 2));
    clear_q();

    // mixed pattern back-to-back, then with random gaps
    for (int r = 0; r < 2; r++) begin
      send_group(pk(10, 20), pk(30, -40), pk(-50, 60), pk(70, 80),
                 pkw(128, 0), pkw(128, 0), pkw(128, 0), 1'b0, r * 3);
      wait_q(4, 40);
      chk_grp(r == 0 ? "mix_b2b" : "mix_gap", 0,
              pk(60, 120), pk(-60, 0), pk(-140, 40), pk(180, -80));
      clear_q();
    end

    // positive saturation, then clr, then negative saturation
    send_group(pk(30000, 0), pk(30000, 0), pk(30000, 0), pk(30000, 0),
               pkw(128, 0), pkw(128, 0), pkw(128, 0), 1'b0, 0);
    wait_q(4, 20);
    chk_grp("sat0", 0, pk(32767, 0), 0, 0, 0);
    chk_grp("sat2", 2, pk(30000, 0), 0, 0, 0);
    check("sat_sf0", sf0, 1);
    check("sat_sf2", sf2, 0);
    clear_q();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_sf0", sf0, 0);
    check("clr_do0", do0, 0);
    send_group(pk(-30000, 0), pk(-30000, 0), pk(-30000, 0), pk(-30000, 0),
               pkw(128, 0), pkw(128, 0), pkw(128, 0), 1'b0, 0);
    wait_q(4, 20);
    chk_grp("nsat0", 0, pk(-32768, 0), 0, 0, 0);
    check("nsat_sf0", sf0, 1);
    clear_q();

    // partial group dropped by clr; sample alongside clr discarded
    drive(pk(9999, 0), pkw(128, 0), 1'b0);
    drive(pk(9999, 0), pkw(128, 0), 1'b0);
    clr = 1'b1;
    drive(pk(7777, 0), pkw(128, 0), 1'b0);
    clr = 1'b0;
    send_group(pk(10, 20), pk(30, -40), pk(-50, 60), pk(70, 80),
               pkw(128, 0), pkw(128, 0), pkw(128, 0), 1'b0, 0);
    wait_q(4, 20);
    chk_grp("flush0", 0, pk(60, 120), pk(-60, 0), pk(-140, 40), pk(180, -80));
    clear_q();

    // reset once f has been emitted
    send_group(pk(1000, 0), 0, 0, 0, pkw(128, 0), pkw(128, 0), pkw(128, 0), 1'b0, 0);
    begin
      int t;
      t = 0;
      while (q0.size() < 2 && t < 20) begin
        @(negedge clk);
        #1;
        t++;
      end
    end
    rst = 1'b0;
    #1;
    check("rstmid_ov0", ov0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("rstmid_count", q0.size(), 2);
    clear_q();

    // 64 continuous groups
    for (int g = 0; g < 64; g++)
      for (int k = 0; k < 4; k++)
        drive((k == 0) ? pk(g * 7 + 1, 0) : 32'd0, pkw(128, 0), 1'b0);
    in_valid = 1'b0;
    wait_q(256, 400);
    begin
      int errs, bubbles;
      errs = 0;
      bubbles = 0;
      for (int i = 0; i < q0.size(); i++) begin
        if (q0[i].d != pk((i / 4) * 7 + 1, 0)) errs++;
        if (i > 0 && q0[i].c != q0[i-1].c + 1) bubbles++;
      end
      check("cont_count", q0.size(), 256);
      check("cont_vals", errs, 0);
      check("cont_bubbles", bubbles, 0);
    end
    clear_q();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
